// File: rtl/i2c_cmd_seq.sv
// i2c_cmd_seq: queues host I2C commands and issues them one at a time to i2c_master (I2C_SEQ_HALT_ON_ERR_EN halts issue while an error is flagged)
module i2c_cmd_seq #(
    parameter int CMD_DEPTH   = 8,
    parameter int RX_DEPTH    = 8,
    parameter int EN_HOLD     = 5,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rd_valid,
    input  logic       rd_ready,
    output logic [7:0] rd_data,
    output logic [6:0] m_addr,
    output logic [7:0] m_tx_data,
    output logic       m_rw,
    output logic       m_i2c_en,
    input  logic       m_ready,
    input  logic       m_is_nack,
    input  logic [7:0] m_rx_data,
    output logic       busy,
    output logic       nack_err,
    output logic       timeout_err,
    input  logic       err_clr
);
    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int HW  = $clog2(EN_HOLD + 1);
    localparam int TW  = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t state, state_n;

    logic [15:0]    cmd_mem [CMD_DEPTH];
    logic [CAW-1:0] cmd_wp, cmd_rp;
    logic [CAW:0]   cmd_cnt;
    logic [15:0]    cmd_head;
    logic           cmd_push, cmd_pop, cmd_empty;

    logic [7:0]     rx_mem [RX_DEPTH];
    logic [RAW-1:0] rx_wp, rx_rp;
    logic [RAW:0]   rx_cnt;
    logic           rx_push, rx_pop, rx_full;

    logic [HW-1:0]  hold_cnt;
    logic [TW-1:0]  wait_cnt;
    logic [7:0]     rx_byte;
    logic           ready_q, nack_seen, complete, timed_out, halt, go;

`ifdef I2C_SEQ_HALT_ON_ERR_EN
    assign halt = nack_err || timeout_err;
`else
    assign halt = 1'b0;
`endif

    assign cmd_empty = cmd_cnt == '0;
    assign cmd_ready = cmd_cnt != (CAW+1)'(CMD_DEPTH);
    assign cmd_head  = cmd_mem[cmd_rp];
    assign cmd_push  = cmd_valid && cmd_ready;
    assign rx_full   = rx_cnt == (RAW+1)'(RX_DEPTH);
    // a read is only issued when its result is guaranteed a slot in the rx FIFO
    assign go        = state == IDLE && !cmd_empty && (!cmd_head[15] || !rx_full) && !halt;
    assign cmd_pop   = go;
    assign rd_valid  = rx_cnt != '0;
    assign rd_data   = rx_mem[rx_rp];
    assign rx_pop    = rd_valid && rd_ready;
    assign rx_push   = state == DONE && m_rw && !nack_seen;
    assign complete  = state == WAIT && m_ready && !ready_q;
    assign timed_out = state == WAIT && !complete && wait_cnt == TW'(TIMEOUT_CYC - 1);
    assign busy      = state != IDLE || !cmd_empty;

    // next-state logic and enable strobe
    always_comb begin
        state_n  = state;
        m_i2c_en = 1'b0;
        unique case (state)
            IDLE:  state_n = go ? ISSUE : IDLE;
            ISSUE: begin
                m_i2c_en = 1'b1;
                state_n  = (hold_cnt == HW'(EN_HOLD - 1)) ? WAIT : ISSUE;
            end
            WAIT:  state_n = complete ? DONE : (timed_out ? IDLE : WAIT);
            DONE:  state_n = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // command FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_wp  <= '0;
            cmd_rp  <= '0;
            cmd_cnt <= '0;
        end else begin
            if (cmd_push) begin
                cmd_mem[cmd_wp] <= {cmd_rw, cmd_addr, cmd_wdata};
                cmd_wp          <= cmd_wp + 1'b1;
            end
            if (cmd_pop) cmd_rp <= cmd_rp + 1'b1;
            cmd_cnt <= cmd_cnt + (CAW+1)'(cmd_push) - (CAW+1)'(cmd_pop);
        end
    end

    // read-data FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (rx_push) begin
                rx_mem[rx_wp] <= rx_byte;
                rx_wp         <= rx_wp + 1'b1;
            end
            if (rx_pop) rx_rp <= rx_rp + 1'b1;
            rx_cnt <= rx_cnt + (RAW+1)'(rx_push) - (RAW+1)'(rx_pop);
        end
    end

    // master-facing command registers, held stable between pops
    always_ff @(posedge clk) begin
        if (rst) begin
            m_rw      <= 1'b0;
            m_addr    <= '0;
            m_tx_data <= '0;
        end else if (cmd_pop) begin
            m_rw      <= cmd_head[15];
            m_addr    <= cmd_head[14:8];
            m_tx_data <= cmd_head[7:0];
        end
    end

    // transaction tracking: enable hold, wait timer, ready edge, nack latch, read byte
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt  <= '0;
            wait_cnt  <= '0;
            ready_q   <= 1'b1;
            nack_seen <= 1'b0;
            rx_byte   <= '0;
        end else begin
            hold_cnt  <= cmd_pop ? '0 : (state == ISSUE ? hold_cnt + 1'b1 : hold_cnt);
            wait_cnt  <= state == WAIT ? wait_cnt + 1'b1 : '0;
            ready_q   <= m_ready;
            nack_seen <= cmd_pop ? 1'b0 : (nack_seen || ((state == ISSUE || state == WAIT) && m_is_nack));
            rx_byte   <= complete ? m_rx_data : rx_byte;
        end
    end

    // sticky error flags; a new error wins over a coincident clear
    always_ff @(posedge clk) begin
        if (rst) begin
            nack_err    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            nack_err    <= (state == DONE && nack_seen) ? 1'b1 : (err_clr ? 1'b0 : nack_err);
            timeout_err <= timed_out ? 1'b1 : (err_clr ? 1'b0 : timeout_err);
        end
    end
endmodule

// File: tb/tb_i2c_cmd_seq.sv
// tb_i2c_cmd_seq: directed self-checking bench for i2c_cmd_seq with a simple i2c_master/slave model
module tb_i2c_cmd_seq;
    logic       clk = 1'b0, rst = 1'b1;
    logic       cmd_valid = 1'b0, cmd_ready, cmd_rw = 1'b0;
    logic [6:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic       rd_valid, rd_ready = 1'b0;
    logic [7:0] rd_data;
    logic [6:0] m_addr;
    logic [7:0] m_tx_data, m_rx_data;
    logic       m_rw, m_i2c_en, m_ready, m_is_nack;
    logic       busy, nack_err, timeout_err, err_clr = 1'b0;

    int checks = 0, failures = 0;
    logic hang = 1'b0;

    logic [7:0] mem [16];
    logic [3:0] widx, ridx;
    logic [4:0] cnt;
    logic       active, cur_rw;
    logic [6:0] cur_addr;
    logic [7:0] cur_wd;

    int          issues = 0;
    logic        en_prev = 1'b0;
    logic [15:0] log_q [$];

    always #5 clk = ~clk;

    i2c_cmd_seq #(.TIMEOUT_CYC(100)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .m_addr(m_addr), .m_tx_data(m_tx_data), .m_rw(m_rw), .m_i2c_en(m_i2c_en),
        .m_ready(m_ready), .m_is_nack(m_is_nack), .m_rx_data(m_rx_data),
        .busy(busy), .nack_err(nack_err), .timeout_err(timeout_err), .err_clr(err_clr)
    );

    // master + slave model: only address 0x50 acks; writes fill mem in order, reads return it in order
    always @(posedge clk) begin
        m_is_nack <= 1'b0;
        if (rst) begin
            m_ready   <= 1'b1;
            m_rx_data <= '0;
            widx      <= '0;
            ridx      <= '0;
            cnt       <= '0;
            active    <= 1'b0;
        end else if (!active && m_i2c_en && m_ready) begin
            active   <= 1'b1;
            m_ready  <= 1'b0;
            cnt      <= 5'd16;
            cur_rw   <= m_rw;
            cur_addr <= m_addr;
            cur_wd   <= m_tx_data;
        end else if (active && !hang) begin
            if (cnt == 0) begin
                active    <= 1'b0;
                m_ready   <= 1'b1;
                m_is_nack <= cur_addr != 7'h50;
                if (cur_addr == 7'h50 && !cur_rw) begin
                    mem[widx] <= cur_wd;
                    widx      <= widx + 1'b1;
                end
                if (cur_addr == 7'h50 && cur_rw) begin
                    m_rx_data <= mem[ridx];
                    ridx      <= ridx + 1'b1;
                end
            end else cnt <= cnt - 1'b1;
        end
    end

    // issue monitor: logs each command at its first enable cycle
    always @(negedge clk) begin
        if (rst) begin
            issues = 0;
            log_q.delete();
            en_prev = 1'b0;
        end else begin
            if (m_i2c_en && !en_prev) begin
                issues = issues + 1;
                log_q.push_back({m_rw, m_addr, m_tx_data});
            end
            en_prev = m_i2c_en;
        end
    end

    task automatic do_reset();
        rst = 1'b1; cmd_valid = 1'b0; rd_ready = 1'b0; err_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push(input logic rw, input logic [6:0] a, input logic [7:0] d);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        if (cmd_ready !== 1'b1) begin
            checks++; failures++;
            $display("FAIL push_wait cmd_ready=%b want 1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = a; cmd_wdata = d;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_issues(input int want, input int budget);
        int n = 0;
        while (issues < want && n < budget) begin @(negedge clk); n++; end
        checks++;
        if (issues < want) begin failures++; $display("FAIL wait_issues got=%0d want=%0d", issues, want); end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin @(negedge clk); n++; end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL wait_idle busy=%b want 0", busy); end
    endtask

    task automatic wait_en_fall();
        int n = 0;
        while (m_i2c_en !== 1'b1 && n < 500) begin @(negedge clk); n++; end
        while (m_i2c_en === 1'b1 && n < 600) begin @(negedge clk); n++; end
        checks++;
        if (m_i2c_en !== 1'b0) begin failures++; $display("FAIL en_fall m_i2c_en=%b want 0", m_i2c_en); end
    endtask

    task automatic pop_check(input logic [7:0] want);
        int n = 0;
        while (rd_valid !== 1'b1 && n < 500) begin @(negedge clk); n++; end
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== want) begin
            failures++; $display("FAIL rd_data got=%h valid=%b want=%h", rd_data, rd_valid, want);
        end
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({cmd_ready, rd_valid, m_i2c_en, m_rw, busy, nack_err, timeout_err} !== 7'b1000000) begin
            failures++; $display("FAIL reset_flags got=%b want=1000000", {cmd_ready, rd_valid, m_i2c_en, m_rw, busy, nack_err, timeout_err});
        end
        checks++;
        if (m_addr !== 7'h00 || m_tx_data !== 8'h00) begin
            failures++; $display("FAIL reset_regs addr=%h tx=%h want 0", m_addr, m_tx_data);
        end
    endtask

    task automatic test_single_write();
        int len = 0;
        do_reset();
        push(1'b0, 7'h50, 8'h01);
        checks++;
        if (m_i2c_en !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL sw_pre en=%b busy=%b want en=0 busy=1", m_i2c_en, busy);
        end
        @(negedge clk);
        checks++;
        if ({m_i2c_en, m_rw, m_addr, m_tx_data} !== {1'b1, 1'b0, 7'h50, 8'h01}) begin
            failures++; $display("FAIL sw_issue got en=%b rw=%b addr=%h tx=%h want 1 0 50 01", m_i2c_en, m_rw, m_addr, m_tx_data);
        end
        while (m_i2c_en === 1'b1 && len < 50) begin len++; @(negedge clk); end
        checks++;
        if (len != 5) begin failures++; $display("FAIL sw_en_len got=%0d want=5", len); end
        checks++;
        if (m_addr !== 7'h50 || m_tx_data !== 8'h01) begin
            failures++; $display("FAIL sw_stable addr=%h tx=%h want 50 01", m_addr, m_tx_data);
        end
        wait_idle(200);
        checks++;
        if ({nack_err, timeout_err, rd_valid} !== 3'b000) begin
            failures++; $display("FAIL sw_done got=%b want=000", {nack_err, timeout_err, rd_valid});
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 9; i++) push(1'b0, 7'h50, 8'(i + 1));
        checks++;
        if (cmd_ready !== 1'b0) begin failures++; $display("FAIL b2b_full cmd_ready=%b want 0", cmd_ready); end
        push(1'b0, 7'h50, 8'h0A);
        for (int i = 0; i < 10; i++) push(1'b1, 7'h50, 8'h00);
        for (int i = 0; i < 10; i++) pop_check(8'(i + 1));
        wait_idle(500);
        checks++;
        if (rd_valid !== 1'b0 || issues != 20) begin
            failures++; $display("FAIL b2b_end rd_valid=%b issues=%0d want 0 20", rd_valid, issues);
        end
        for (int i = 0; i < 20 && i < log_q.size(); i++) begin
            logic [15:0] exp;
            exp = i < 10 ? {1'b0, 7'h50, 8'(i + 1)} : {1'b1, 7'h50, 8'h00};
            checks++;
            if (log_q[i] !== exp) begin failures++; $display("FAIL b2b_order[%0d] got=%h want=%h", i, log_q[i], exp); end
        end
    endtask

    task automatic test_rx_full();
        do_reset();
        for (int i = 0; i < 9; i++) push(1'b1, 7'h50, 8'h00);
        wait_issues(8, 1000);
        repeat (100) @(negedge clk);
        checks++;
        if (issues != 8 || busy !== 1'b1 || rd_valid !== 1'b1) begin
            failures++; $display("FAIL rxf_stall issues=%0d busy=%b valid=%b want 8 1 1", issues, busy, rd_valid);
        end
        pop_check(8'h01);
        wait_issues(9, 100);
        wait_idle(200);
        for (int i = 2; i <= 9; i++) pop_check(8'(i));
        checks++;
        if (rd_valid !== 1'b0) begin failures++; $display("FAIL rxf_empty rd_valid=%b want 0", rd_valid); end
    endtask

    task automatic test_nack();
        do_reset();
        push(1'b0, 7'h23, 8'h55);
        push(1'b0, 7'h50, 8'h77);
`ifdef I2C_SEQ_HALT_ON_ERR_EN
        for (int n = 0; n < 300 && nack_err !== 1'b1; n++) @(negedge clk);
        repeat (100) @(negedge clk);
        checks++;
        if (nack_err !== 1'b1 || issues != 1) begin
            failures++; $display("FAIL nack_halt nack_err=%b issues=%0d want 1 1", nack_err, issues);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++;
        if (nack_err !== 1'b0) begin failures++; $display("FAIL nack_clr nack_err=%b want 0", nack_err); end
        wait_issues(2, 50);
        wait_idle(200);
`else
        wait_issues(2, 500);
        wait_idle(200);
        checks++;
        if (nack_err !== 1'b1) begin failures++; $display("FAIL nack_err got=%b want 1", nack_err); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++;
        if (nack_err !== 1'b0) begin failures++; $display("FAIL nack_clr nack_err=%b want 0", nack_err); end
`endif
        checks++;
        if (log_q.size() < 2 || log_q[1] !== {1'b0, 7'h50, 8'h77}) begin
            failures++; $display("FAIL nack_next got=%h want=5077", log_q.size() < 2 ? 16'h0 : log_q[1]);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        hang = 1'b1;
        push(1'b0, 7'h50, 8'h11);
        wait_en_fall();
        repeat (99) @(negedge clk);
        checks++;
        if (timeout_err !== 1'b0) begin failures++; $display("FAIL to_early timeout_err=%b want 0", timeout_err); end
        @(negedge clk);
        checks++;
        if (timeout_err !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL to_set timeout_err=%b busy=%b want 1 0", timeout_err, busy);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++;
        if (timeout_err !== 1'b0) begin failures++; $display("FAIL to_clr timeout_err=%b want 0", timeout_err); end
        push(1'b0, 7'h50, 8'h22);
        wait_en_fall();
        repeat (99) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++;
        if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_set_wins timeout_err=%b want 1", timeout_err); end
        hang = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        do_reset();
        for (int i = 0; i < 3; i++) push(1'b0, 7'h50, 8'(8'h30 + i));
        while (m_i2c_en !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        checks++;
        if (m_i2c_en !== 1'b1) begin failures++; $display("FAIL rm_issue m_i2c_en=%b want 1", m_i2c_en); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({m_i2c_en, cmd_ready, rd_valid, busy, nack_err, timeout_err} !== 6'b010000 || m_addr !== 7'h00) begin
            failures++; $display("FAIL rm_reset got=%b addr=%h want=010000 00", {m_i2c_en, cmd_ready, rd_valid, busy, nack_err, timeout_err}, m_addr);
        end
        rst = 1'b0;
        repeat (100) @(negedge clk);
        checks++;
        if (issues != 0 || busy !== 1'b0) begin
            failures++; $display("FAIL rm_quiet issues=%0d busy=%b want 0 0", issues, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_rx_full();
        test_nack();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
